// File: rtl/div_iter_pkg.sv
// div_iter_pkg: shared state encoding and default widths for the iterative divider.
package div_iter_pkg;
  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 6;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} div_state_e;
endpackage

// File: rtl/div_iter_step.sv
// div_step: one restoring radix-2 iteration (shift {rem,quot} left, trial subtract, select).
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quot_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quot_o
);
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             ge;
  assign shifted = {rem_i, quot_i[WIDTH-1]};
  assign trial   = {1'b0, shifted} - {2'b00, dvs_i};
  assign ge      = ~trial[WIDTH+1];
  // A successful trial is always below the divisor, so it fits back in WIDTH bits.
  assign rem_o   = ge ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quot_o  = {quot_i[WIDTH-2:0], ge};
endmodule

// File: rtl/div_iter.sv
// div_iter: multi-cycle DIV/DIVU unit; quotient to LO, remainder to HI, stalls execute until done.
module div_iter
  import div_iter_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             div_en,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             stall_other,
  input  logic             flush,
  output logic             div_stall,
  output logic             result_valid,
  output logic [WIDTH-1:0] lo_out,
  output logic [WIDTH-1:0] hi_out
);
  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, quot_q, quot_d, dvs_q, dvs_d, lo_q, lo_d, hi_q, hi_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d;
  logic [WIDTH-1:0] step_rem, step_quot;
  logic             sdd, sdv;
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quot_i(quot_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quot_o(step_quot)
  );
  assign sdd          = signed_div & dividend[WIDTH-1];
  assign sdv          = signed_div & divisor[WIDTH-1];
  assign div_stall    = resetn & div_en & (state_q != DONE) & ~flush;
  assign result_valid = state_q == DONE;
  assign lo_out       = lo_q;
  assign hi_out       = hi_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (div_en) begin
          state_d = BUSY;
          cnt_d   = '0;
          rem_d   = '0;
          quot_d  = sdd ? -dividend : dividend;
          dvs_d   = sdv ? -divisor : divisor;
          qneg_d  = sdd ^ sdv;
          rneg_d  = sdd;
        end
        BUSY: if (!div_en) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          rem_d  = step_rem;
          quot_d = step_quot;
          cnt_d  = cnt_q + 1'b1;
          // Final step: capture sign-corrected results so they are ready on DONE entry.
          if (cnt_q == CNT_W'(WIDTH-1)) begin
            state_d = DONE;
            lo_d    = qneg_q ? -step_quot : step_quot;
            hi_d    = rneg_q ? -step_rem : step_rem;
          end
        end
        DONE: state_d = stall_other ? DONE : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end
endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
- Multi-cycle iterative divider for the execute stage.
- Services DIV and DIVU, writing quotient to LO and remainder to HI.
- Is the producer of the div_stall request consumed by the hazard unit.
- Holds execute (and everything upstream) until the result is ready, then keeps the result stable for as long as other stall sources (i_stall/d_stall) keep execute frozen.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 6, iteration counter width (must hold WIDTH).

Ports:
- clk  in  1  core clock.
- resetn  in  1  asynchronous active-low reset.
- div_en  in  1  valid DIV/DIVU instruction present in execute.
- signed_div  in  1  1 = DIV (signed), 0 = DIVU.
- dividend  in  WIDTH  rs value after forwarding.
- divisor  in  WIDTH  rt value after forwarding.
- stall_other  in  1  i_stall | d_stall; execute will not advance while high.
- flush  in  1  execute flush / exception abort.
- div_stall  out  1  stall request to the hazard unit.
- result_valid  out  1  quotient/remainder valid this cycle.
- lo_out  out  WIDTH  quotient.
- hi_out  out  WIDTH  remainder.

Behaviour:
- Reset (resetn low, asynchronous): state IDLE, counter 0, all datapath registers 0. result_valid=0, lo_out=0, hi_out=0, div_stall=0.
- States: IDLE, BUSY, DONE.
- div_stall is combinational: div_en & (state != DONE) & ~flush.
- IDLE, div_en=1, flush=0:
  - Latch |dividend| and |divisor| (absolute values only when signed_div=1).
  - Latch sign flags.
  - Clear partial remainder; counter=0; go BUSY.
  - div_stall is high in this cycle.
- BUSY, one restoring radix-2 step per cycle:
  - shift {rem,quot} left by 1.
  - trial = rem - divisor.
  - if trial is non-negative: rem=trial, quot LSB=1.
  - counter increments each step; after the WIDTH-th step (counter==WIDTH-1) go DONE.
- DONE:
  - result_valid=1, div_stall=0.
  - lo_out/hi_out are sign-corrected:
    - quotient negated when signs differ.
    - remainder takes the dividend's sign.
  - Stay in DONE while stall_other=1.
  - When stall_other=0, execute advances this cycle; next state IDLE.
- Latency: en sampled at cycle T; div_stall high T..T+WIDTH; result_valid first high at T+WIDTH+1.
- Back-to-back divides: the second div_en is seen in IDLE the cycle after DONE exits, and a new operation starts with no bubble.
- Divide by zero: no trap. Quotient = all ones (before sign fix), remainder = dividend. The result is deterministic.
- Overflow (0x80000000 / -1 signed): lo=0x80000000, hi=0.
- flush=1 in any state: next state IDLE, counter 0, result_valid deasserted next cycle. flush takes priority over a start in the same cycle.
- div_en dropping while BUSY: abort to IDLE, no result.
- Operands are latched only at start; operand changes during BUSY are ignored.
- lo_out/hi_out hold their last value outside DONE. Consumers qualify them with result_valid.

Decomposition:
- Shared package: state encoding constants (IDLE/BUSY/DONE) and the WIDTH default, alongside the pipeline defines.
- One natural sub-module, div_step: combinational shift/subtract/select for a single iteration. It is instantiated once and keeps the FSM file readable.
- Sign pre/post correction stays in div_iter.

Test Plan:
- DIVU 100/7, stall_other=0 -> div_stall high 33 cycles; result_valid for 1 cycle; lo=14, hi=2; then IDLE.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 5/0 -> lo=0xFFFFFFFF, hi=5. DIV -5/0 -> hi=0xFFFFFFFB, no hang, 33-cycle stall.
- stall_other held high 4 cycles after completion -> result_valid and lo/hi stable for 5 cycles, div_stall low throughout, IDLE after stall_other falls.
- flush at iteration 10 of DIVU 1000/3 -> IDLE next cycle, div_stall low, no result_valid; new DIVU 9/3 then gives lo=3, hi=0.
- Two consecutive DIVUs (20/6 then 50/8) -> results lo=3,hi=2 then lo=6,hi=2; second starts the cycle after the first exits DONE; async reset asserted mid-BUSY returns all outputs to 0 immediately.
